// File: rtl/snoop_pkg.sv
// Shared definitions for the snoop loader: host command opcodes and the
// command-sequencer state encoding.
package snoop_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_CLEAR  = 8'h03;
  localparam logic [7:0] OP_PWRITE = 8'h10;
  localparam logic [7:0] OP_MWRITE = 8'h20;
  localparam logic [7:0] OP_MREAD  = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_ADDR  = 3'd1,
    S_GET_COUNT = 3'd2,
    S_WDATA     = 3'd3,
    S_RADDR     = 3'd4,
    S_RWAIT     = 3'd5,
    S_RSEND     = 3'd6
  } state_t;

endpackage

// File: rtl/snoop_timeout.sv
// Idle-cycle watchdog for the snoop loader.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_clear        : restart the count (byte accepted / read handshake)
//   i_enable       : count this cycle (waiting on the host); low also restarts
//   o_tick         : the count reaches all-ones at the coming edge
// TIMEOUT_BITS = 0 removes the counter and o_tick is tied low.
module snoop_timeout #(
  parameter int TIMEOUT_BITS = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  generate
    if (TIMEOUT_BITS > 0) begin : g_cnt
      localparam logic [TIMEOUT_BITS-1:0] LP_LAST = {TIMEOUT_BITS{1'b1}} - 1'b1;

      logic [TIMEOUT_BITS-1:0] r_count;

      always_ff @(posedge i_clk) begin
        if (i_reset || i_clear || !i_enable) begin
          r_count <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end

      // Fire one cycle early so the abort lands on the edge where the count
      // becomes all-ones; a clear in the same cycle always wins.
      assign o_tick = i_enable && !i_clear && (r_count == LP_LAST);
    end else begin : g_none
      assign o_tick = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/snoop_loader.sv
// Host-side sequencer for the CPU core's snoop port. Byte commands from the
// host load program RAM, write/read data memory and control the core reset.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_data/valid/ready   : command byte stream from host
//   out_data/valid/ready  : read-back byte stream to host
//   snoopa/snoopd         : snoop address / write data to core
//   snoopq                : snoop read data from core (core registers on negedge)
//   snoopm/snoopp         : data-memory / program-RAM write strobes (1 cycle)
//   cpu_reset             : core reset
//   busy                  : a command is in progress
//   error                 : sticky protocol error (cleared by CLEAR)
module snoop_loader #(
  parameter logic BOOT_HALTED  = 1'b1,
  parameter int   TIMEOUT_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] snoopa,
  output logic [7:0] snoopd,
  input  logic [7:0] snoopq,
  output logic       snoopm,
  output logic       snoopp,
  output logic       cpu_reset,
  output logic       busy,
  output logic       error
);

  import snoop_pkg::*;

  state_t     r_state,  w_state_nxt;
  logic [7:0] r_op,     w_op_nxt;
  logic [7:0] r_addr,   w_addr_nxt;
  logic [7:0] r_count,  w_count_nxt;
  logic [7:0] r_snoopa, w_snoopa_nxt;
  logic [7:0] r_snoopd, w_snoopd_nxt;
  logic       r_snoopm, w_snoopm_nxt;
  logic       r_snoopp, w_snoopp_nxt;
  logic [7:0] r_out_data,  w_out_data_nxt;
  logic       r_out_valid, w_out_valid_nxt;
  logic       r_cpu_reset, w_cpu_reset_nxt;
  logic       r_error,     w_error_nxt;

  logic w_in_fire;
  logic w_out_fire;
  logic w_last;
  logic w_to_enable;
  logic w_to_tick;

  assign in_ready   = (r_state == S_IDLE)     || (r_state == S_GET_ADDR) ||
                      (r_state == S_GET_COUNT) || (r_state == S_WDATA);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;
  // Count 0 encodes 256: decrementing from 0 wraps to 255 and the block ends at 1.
  assign w_last     = (r_count == 8'd1);

  // Only states that wait on the host may time out.
  assign w_to_enable = (r_state == S_GET_ADDR) || (r_state == S_GET_COUNT) ||
                       (r_state == S_WDATA)    || (r_state == S_RSEND);

  snoop_timeout #(
    .TIMEOUT_BITS(TIMEOUT_BITS)
  ) u_timeout (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_clear  (w_in_fire || w_out_fire),
    .i_enable (w_to_enable),
    .o_tick   (w_to_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_snoopa    <= 8'h00;
      r_snoopd    <= 8'h00;
      r_snoopm    <= 1'b0;
      r_snoopp    <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_cpu_reset <= BOOT_HALTED;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_snoopa    <= w_snoopa_nxt;
      r_snoopd    <= w_snoopd_nxt;
      r_snoopm    <= w_snoopm_nxt;
      r_snoopp    <= w_snoopp_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_error     <= w_error_nxt;
    end
  end

  // Command operands are always written before they are used.
  always_ff @(posedge clk) begin
    r_op    <= w_op_nxt;
    r_addr  <= w_addr_nxt;
    r_count <= w_count_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_op_nxt        = r_op;
    w_addr_nxt      = r_addr;
    w_count_nxt     = r_count;
    w_snoopa_nxt    = r_snoopa;
    w_snoopd_nxt    = r_snoopd;
    w_snoopm_nxt    = 1'b0;
    w_snoopp_nxt    = 1'b0;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_cpu_reset_nxt = r_cpu_reset;
    w_error_nxt     = r_error;

    case (r_state)
      S_IDLE: begin
        if (w_in_fire) begin
          case (in_data)
            OP_NOP:   ;
            OP_HALT:  w_cpu_reset_nxt = 1'b1;
            OP_RUN:   w_cpu_reset_nxt = 1'b0;
            OP_CLEAR: w_error_nxt     = 1'b0;
            OP_PWRITE, OP_MWRITE, OP_MREAD: begin
              // Memory access is only safe with the core held in reset.
              w_op_nxt        = in_data;
              w_cpu_reset_nxt = 1'b1;
              w_state_nxt     = S_GET_ADDR;
            end
            default:  w_error_nxt     = 1'b1;
          endcase
        end
      end
      S_GET_ADDR: begin
        if (w_in_fire) begin
          w_addr_nxt  = in_data;
          w_state_nxt = S_GET_COUNT;
        end
      end
      S_GET_COUNT: begin
        if (w_in_fire) begin
          w_count_nxt = in_data;
          w_state_nxt = (r_op == OP_MREAD) ? S_RADDR : S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_in_fire) begin
          w_snoopa_nxt = r_addr;
          w_snoopd_nxt = in_data;
          if (r_op == OP_PWRITE) begin
            w_snoopp_nxt = 1'b1;
          end else begin
            w_snoopm_nxt = 1'b1;
          end
          w_addr_nxt  = r_addr + 8'd1;
          w_count_nxt = r_count - 8'd1;
          if (w_last) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RADDR: begin
        // Address is presented during RWAIT; the core samples it on that
        // cycle's negedge so snoopq is ready at the RWAIT->RSEND edge.
        w_snoopa_nxt = r_addr;
        w_state_nxt  = S_RWAIT;
      end
      S_RWAIT: begin
        w_out_data_nxt  = snoopq;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_RSEND;
      end
      S_RSEND: begin
        if (w_out_fire) begin
          w_out_valid_nxt = 1'b0;
          w_addr_nxt      = r_addr + 8'd1;
          w_count_nxt     = r_count - 8'd1;
          w_state_nxt     = w_last ? S_IDLE : S_RADDR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_to_tick) begin
      w_state_nxt     = S_IDLE;
      w_error_nxt     = 1'b1;
      w_out_valid_nxt = 1'b0;
      w_snoopm_nxt    = 1'b0;
      w_snoopp_nxt    = 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign snoopa    = r_snoopa;
  assign snoopd    = r_snoopd;
  assign snoopm    = r_snoopm;
  assign snoopp    = r_snoopp;
  assign cpu_reset = r_cpu_reset;
  assign busy      = (r_state != S_IDLE);
  assign error     = r_error;

endmodule

// File: tb/tb_snoop_loader.sv
// Directed bench for snoop_loader, with a small negedge core-memory model.
module tb_snoop_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] snoopa;
  logic [7:0] snoopd;
  logic [7:0] snoopq;
  logic       snoopm;
  logic       snoopp;
  logic       cpu_reset;
  logic       busy;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] dmem [256];
  logic [7:0] pmem [256];

  snoop_loader #(
    .BOOT_HALTED (1'b1),
    .TIMEOUT_BITS(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .snoopa   (snoopa),
    .snoopd   (snoopd),
    .snoopq   (snoopq),
    .snoopm   (snoopm),
    .snoopp   (snoopp),
    .cpu_reset(cpu_reset),
    .busy     (busy),
    .error    (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Core memories run on the falling edge.
  always @(negedge clk) begin
    if (snoopm) dmem[snoopa] <= snoopd;
    if (snoopp) pmem[snoopa] <= snoopd;
    snoopq <= dmem[snoopa];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pd [3];
    logic [7:0] md [3];
    logic [7:0] ma [3];
    pd = '{8'hA1, 8'hB2, 8'hC3};
    md = '{8'h11, 8'h22, 8'h33};
    ma = '{8'hFE, 8'hFF, 8'h00};

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    check("rst_snoopm", snoopm, 0);
    check("rst_snoopp", snoopp, 0);
    check("rst_snoopa", snoopa, 8'h00);
    check("rst_snoopd", snoopd, 8'h00);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // PWRITE 3 bytes at 0x00, back-to-back
    put(8'h10);
    check("pw_halt", cpu_reset, 1);
    check("pw_busy_op", busy, 1);
    put(8'h00);
    put(8'h03);
    for (int i = 0; i < 3; i++) begin
      put(pd[i]);
      check("pw_snoopp", snoopp, 1);
      check("pw_snoopm", snoopm, 0);
      check("pw_addr", snoopa, i);
      check("pw_data", snoopd, pd[i]);
      check("pw_busy", busy, (i < 2) ? 1 : 0);
    end
    idle();
    step();
    check("pw_strobe_off", snoopp, 0);
    check("pw_addr_hold", snoopa, 8'h02);
    check("pw_cpu_reset", cpu_reset, 1);
    for (int i = 0; i < 3; i++) check("pw_pmem", pmem[i], pd[i]);

    // MWRITE 3 bytes at 0xFE with address wrap
    put(8'h20); put(8'hFE); put(8'h03);
    for (int i = 0; i < 3; i++) begin
      put(md[i]);
      check("mw_snoopm", snoopm, 1);
      check("mw_snoopp", snoopp, 0);
      check("mw_addr", snoopa, ma[i]);
      check("mw_data", snoopd, md[i]);
    end
    idle();
    step();
    check("mw_strobe_off", snoopm, 0);

    // MREAD 3 bytes at 0xFE, host always ready: one byte every 3 cycles
    put(8'h30); put(8'hFE); put(8'h03);
    idle();
    out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      check("rd_valid", out_valid, (k == 2 || k == 5 || k == 8) ? 1 : 0);
      check("rd_in_ready", in_ready, (k == 9) ? 1 : 0);
      if (k == 2) check("rd_data0", out_data, 8'h11);
      if (k == 5) check("rd_data1", out_data, 8'h22);
      if (k == 8) check("rd_data2", out_data, 8'h33);
    end
    check("rd_busy_end", busy, 0);
    out_ready = 1'b0;

    // MREAD with host stalled for 10 cycles
    put(8'h30); put(8'hFE); put(8'h02);
    idle();
    step();
    step();
    check("st_valid0", out_valid, 1);
    check("st_data0", out_data, 8'h11);
    for (int k = 0; k < 10; k++) begin
      step();
      check("st_valid_hold", out_valid, 1);
      check("st_data_hold", out_data, 8'h11);
      check("st_in_ready", in_ready, 0);
      check("st_addr_hold", snoopa, 8'hFE);
    end
    out_ready = 1'b1;
    step();
    check("st_valid_drop", out_valid, 0);
    step();
    check("st_next_addr", snoopa, 8'hFF);
    step();
    check("st_valid1", out_valid, 1);
    check("st_data1", out_data, 8'h22);
    step();
    check("st_valid_end", out_valid, 0);
    check("st_busy_end", busy, 0);
    check("st_no_error", error, 0);
    out_ready = 1'b0;

    // RUN / HALT / block opcode forces halt / bad opcode / CLEAR
    put(8'h02);
    check("run", cpu_reset, 0);
    put(8'h01);
    check("halt", cpu_reset, 1);
    put(8'h02);
    check("run2", cpu_reset, 0);
    put(8'h20);
    check("op_halts", cpu_reset, 1);
    put(8'h00); put(8'h01); put(8'h55);
    check("mw1_strobe", snoopm, 1);
    check("mw1_busy", busy, 0);
    put(8'h7F);
    check("bad_op_err", error, 1);
    check("bad_op_busy", busy, 0);
    put(8'h03);
    check("clear_err", error, 0);
    idle();

    // Timeout after 15 idle cycles in GET_COUNT
    put(8'h10); put(8'h05);
    idle();
    for (int k = 1; k <= 15; k++) begin
      step();
      check("to_snoopp", snoopp, 0);
      check("to_busy", busy, (k < 15) ? 1 : 0);
      if (k == 14) check("to_err_early", error, 0);
    end
    check("to_error", error, 1);
    put(8'h03);
    check("to_opcode_busy", busy, 0);
    check("to_opcode_clear", error, 0);

    // Reset while a program write strobe is high
    put(8'h10); put(8'h40); put(8'h04); put(8'hAA);
    check("rw_strobe", snoopp, 1);
    reset = 1'b1;
    in_data = 8'hBB;
    step();
    check("rw_snoopp", snoopp, 0);
    check("rw_out_valid", out_valid, 0);
    check("rw_cpu_reset", cpu_reset, 1);
    check("rw_busy", busy, 0);
    check("rw_in_ready", in_ready, 1);
    reset = 1'b0;
    idle();
    step();
    check("rw_after", snoopp, 0);
    check("rw_after_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
